alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  Decode-to-execute stage placed directly upstream of the 32-bit ALU. Holds a 32x32 register file,
//  reads rs/rt, forms operand B (register or extended immediate), tracks in-flight destinations with
//  a scoreboard, and registers A/B/Fun/rd into a valid/ready pipeline slot whose outputs drive the ALU.
//  The writeback port returns ALU results into the register file.
// PARAMETERS
//  DATA_W  32  operand / register width
//  ADDR_W  5   register address width (2**ADDR_W registers; register 0 reads as zero)
// PORTS
//  clk       in   1       single clock, all state on rising edge
//  rst       in   1       synchronous, active-high reset
//  in_valid  in   1       decoded instruction present
//  in_ready  out  1       stage accepts instruction this cycle
//  in_rs     in   ADDR_W  source register for A
//  in_rt     in   ADDR_W  source register for B (ignored when in_use_imm=1)
//  in_rd     in   ADDR_W  destination register (0 = no write)
//  in_imm    in   16      immediate field
//  in_use_imm in  1       1: B from immediate, 0: B from rt
//  in_fun    in   3       ALU function: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//  wb_en     in   1       writeback strobe
//  wb_addr   in   ADDR_W  writeback register
//  wb_data   in   DATA_W  writeback value
//  out_valid out  1       A/B/Fun/rd valid for ALU
//  out_ready in   1       downstream consumes slot this cycle
//  out_A     out  DATA_W  ALU operand A
//  out_B     out  DATA_W  ALU operand B
//  out_Fun   out  3       ALU function
//  out_rd    out  ADDR_W  destination carried to writeback
// BEHAVIOUR
//  - Reset: all registers 0, scoreboard clear, out_valid=0, out_A=out_B=0, out_Fun=0, out_rd=0.
//  - Accept = in_valid & in_ready; in_ready = (~out_valid | out_ready) & ~hazard. Latency 1 cycle.
//  - Output slot holds all fields stable while out_valid & ~out_ready; clears out_valid on
//    out_ready without a new accept.
//  - Register file: write at edge when wb_en & wb_addr!=0; writes to reg 0 discarded; reg 0 reads 0.
//  - Bypass: read of reg r in the same cycle as wb_en & wb_addr==r (r!=0) returns wb_data.
//  - Immediate: in_fun[1]=0 (AND/OR) zero-extend; otherwise sign-extend imm[15] to DATA_W.
//  - Scoreboard: pending[r] set on accept with in_rd=r (r!=0); cleared on wb_en & wb_addr=r.
//    Same-cycle set and clear of one register: set wins.
//  - Hazard (RAW/WAW): pending[rs], pending[rt] (only if ~in_use_imm), or pending[rd] is set
//    (each for non-zero addresses) and that register is not being written back this cycle.
//  - in_rs/in_rt/in_rd index 0 never cause a hazard.
//  - wb_en to a non-pending register is legal: data written, scoreboard unchanged.
//  - rst mid-operation drops the slot (out_valid=0) and clears all state the next edge, ignoring
//    in_valid and wb_en in that cycle.
//  - Combinational paths: in_ready depends on out_ready, in_* and wb_*; no path from in_* to out_*.
// TESTING
//  - Reset, then wb r1=5, r2=3; issue rs=1 rt=2 rd=3 Fun=010 -> next cycle out_valid=1 A=5 B=3 Fun=010 rd=3.
//  - Issue use_imm=1 imm=16'hFFFF Fun=010 -> B=32'hFFFFFFFF; same imm with Fun=001 -> B=32'h0000FFFF.
//  - Issue rd=3, then rs=3 next cycle without wb -> in_ready=0; wb r3=8 -> accepted same cycle, A=8.
//  - Hold out_ready=0 two cycles with out_valid=1 -> out_* stable, in_ready=0; release -> new slot loads.
//  - wb r0=99 then read rs=0 -> A=0; issue rd=0 -> no scoreboard bit set, no later stall.
//  - Assert rst while out_valid=1 and r3 pending -> next cycle out_valid=0, in_ready=1, r3 reads 0.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Decode-to-execute stage feeding the ALU: register file with writeback bypass,
// immediate extension, in-flight destination scoreboard and a valid/ready output slot.
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [15:0]       in_imm,
  input  logic              in_use_imm,
  input  logic [2:0]        in_fun,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_A,
  output logic [DATA_W-1:0] out_B,
  output logic [2:0]        out_Fun,
  output logic [ADDR_W-1:0] out_rd
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] rf [NREG];
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_nxt;

  logic              vld_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic [2:0]        fun_p1;
  logic [ADDR_W-1:0] rd_p1;

  logic              wb_live;
  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;

  // AND/OR take the immediate as a bit pattern; arithmetic ops treat it as signed.
  function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] imm, input logic [2:0] fun);
    if (fun[1]) return {{(DATA_W-16){imm[15]}}, imm};
    else        return {{(DATA_W-16){1'b0}}, imm};
  endfunction

  function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W-1:0] r);
    if (r == '0)                    return '0;
    else if (wb_live && wb_addr == r) return wb_data;
    else                            return rf[r];
  endfunction

  function automatic logic busy(input logic [ADDR_W-1:0] r);
    return (r != '0) && pending[r] && !(wb_live && wb_addr == r);
  endfunction

  // Stage p0: operand read, hazard detection, scoreboard next state
  always_comb begin
    wb_live  = wb_en && (wb_addr != '0);
    hazard   = busy(in_rs) || (!in_use_imm && busy(in_rt)) || busy(in_rd);
    in_ready = (!vld_p1 || out_ready) && !hazard;
    accept   = in_valid && in_ready;
    a_p0     = read_reg(in_rs);
    b_p0     = in_use_imm ? ext_imm(in_imm, in_fun) : read_reg(in_rt);

    pending_nxt = pending;
    if (wb_live)                 pending_nxt[wb_addr] = 1'b0;
    if (accept && in_rd != '0)   pending_nxt[in_rd]   = 1'b1;
  end

  // Stage p1: register file, scoreboard and output slot
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      pending <= '0;
      vld_p1  <= 1'b0;
      a_p1    <= '0;
      b_p1    <= '0;
      fun_p1  <= '0;
      rd_p1   <= '0;
    end else begin
      if (wb_live) rf[wb_addr] <= wb_data;
      pending <= pending_nxt;
      if (accept) begin
        vld_p1 <= 1'b1;
        a_p1   <= a_p0;
        b_p1   <= b_p0;
        fun_p1 <= in_fun;
        rd_p1  <= in_rd;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_A     = a_p1;
  assign out_B     = b_p1;
  assign out_Fun   = fun_p1;
  assign out_rd    = rd_p1;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: operand read, immediates, stalls,
// back-pressure, register 0 handling and mid-operation reset.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic        in_use_imm;
  logic [2:0]  in_fun;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_A, out_B;
  logic [2:0]  out_Fun;
  logic [4:0]  out_rd;

  int n_tests = 0;
  int n_fail  = 0;

  alu_operand_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_fun(in_fun),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_A(out_A), .out_B(out_B), .out_Fun(out_Fun), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic use_imm, input logic [15:0] imm, input logic [2:0] fun);
    in_valid   = 1'b1;
    in_rs      = rs;
    in_rt      = rt;
    in_rd      = rd;
    in_use_imm = use_imm;
    in_imm     = imm;
    in_fun     = fun;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wb_en   = en;
    wb_addr = addr;
    wb_data = data;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_use_imm = 1'b0; in_fun = '0;
    wb(1'b0, 5'd0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_A", out_A, 32'd0);
    check("rst_B", out_B, 32'd0);
    check("rst_Fun", {29'd0, out_Fun}, 32'd0);
    check("rst_rd", {27'd0, out_rd}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    // r1=5, r2=3, then ADD r3 = r1 + r2
    wb(1'b1, 5'd1, 32'd5); tick();
    wb(1'b1, 5'd2, 32'd3); tick();
    wb(1'b0, 5'd0, 32'd0);
    issue(5'd1, 5'd2, 5'd3, 1'b0, 16'h0, 3'b010);
    #1 check("add_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_A", out_A, 32'd5);
    check("add_B", out_B, 32'd3);
    check("add_Fun", {29'd0, out_Fun}, 32'd2);
    check("add_rd", {27'd0, out_rd}, 32'd3);

    // Immediates: sign-extended for ADD, zero-extended for OR
    issue(5'd1, 5'd0, 5'd0, 1'b1, 16'hFFFF, 3'b010); tick();
    check("imm_sx_B", out_B, 32'hFFFF_FFFF);
    check("imm_sx_A", out_A, 32'd5);
    issue(5'd1, 5'd0, 5'd0, 1'b1, 16'hFFFF, 3'b001); tick();
    in_valid = 1'b0;
    check("imm_zx_B", out_B, 32'h0000_FFFF);
    check("imm_zx_Fun", {29'd0, out_Fun}, 32'd1);

    // RAW on pending r3 stalls until writeback, which is bypassed
    issue(5'd3, 5'd0, 5'd0, 1'b1, 16'h0, 3'b010);
    #1 check("raw_stall", {31'd0, in_ready}, 32'd0);
    tick();
    check("raw_drain", {31'd0, out_valid}, 32'd0);
    wb(1'b1, 5'd3, 32'd8);
    #1 check("raw_release", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; wb(1'b0, 5'd0, 32'd0);
    check("bypass_valid", {31'd0, out_valid}, 32'd1);
    check("bypass_A", out_A, 32'd8);

    // Back-pressure: slot holds while out_ready=0
    issue(5'd1, 5'd2, 5'd4, 1'b0, 16'h0, 3'b110); tick();
    out_ready = 1'b0;
    issue(5'd2, 5'd1, 5'd5, 1'b0, 16'h0, 3'b000);
    #1 check("hold_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("hold1_valid", {31'd0, out_valid}, 32'd1);
    check("hold1_A", out_A, 32'd5);
    check("hold1_rd", {27'd0, out_rd}, 32'd4);
    tick();
    check("hold2_A", out_A, 32'd5);
    check("hold2_B", out_B, 32'd3);
    check("hold2_Fun", {29'd0, out_Fun}, 32'd6);
    out_ready = 1'b1;
    #1 check("release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("release_A", out_A, 32'd3);
    check("release_B", out_B, 32'd5);
    check("release_Fun", {29'd0, out_Fun}, 32'd0);
    check("release_rd", {27'd0, out_rd}, 32'd5);

    // Register 0: writes discarded, never a hazard
    wb(1'b1, 5'd0, 32'd99); tick();
    wb(1'b0, 5'd0, 32'd0);
    issue(5'd0, 5'd0, 5'd0, 1'b0, 16'h0, 3'b010); tick();
    check("r0_A", out_A, 32'd0);
    check("r0_B", out_B, 32'd0);
    #1 check("r0_no_stall", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("r0_valid", {31'd0, out_valid}, 32'd1);

    // Writeback to a non-pending register is plain data
    wb(1'b1, 5'd6, 32'd7); tick();
    wb(1'b0, 5'd0, 32'd0);
    issue(5'd6, 5'd0, 5'd6, 1'b0, 16'h0, 3'b010);
    #1 check("np_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("np_A", out_A, 32'd7);

    // Mid-operation reset with r3 pending and slot full
    issue(5'd1, 5'd2, 5'd3, 1'b0, 16'h0, 3'b010); tick();
    out_ready = 1'b0;
    rst = 1'b1;
    wb(1'b1, 5'd7, 32'd1);
    tick();
    rst = 1'b0; in_valid = 1'b0; wb(1'b0, 5'd0, 32'd0);
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_A", out_A, 32'd0);
    out_ready = 1'b1;
    issue(5'd3, 5'd7, 5'd3, 1'b0, 16'h0, 3'b010);
    #1 check("mrst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("mrst_r3", out_A, 32'd0);
    check("mrst_r7", out_B, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
